sensor_chuva: RTL

- Producer side of the 2-bit rain code consumed by the irrigation controller.
- Converts raw pulses from a tipping-bucket rain gauge into the classified code: 0 nenhuma, 1 pouca, 2 muita, 3 dilúvio.
- Counts gauge pulses over a fixed window of clock cycles and publishes one classification per window, with a 1-cycle valid strobe.
- Sits between the gauge input (a switch or pin) and the chuva input of the irrigation FSM.

---
 rtl/pkg_irrigacao.sv | 27 ++
 rtl/sincroniza_borda.sv | 28 ++
 rtl/sensor_chuva.sv | 105 ++++++++++
 3 files changed

// File: rtl/pkg_irrigacao.sv
// Types shared between the rain sensor and the irrigation controller,
// plus the pulse-count classification rule.
package pkg_irrigacao;

   typedef enum logic [1:0] {
      NENHUMA = 2'd0,
      POUCA   = 2'd1,
      MUITA   = 2'd2,
      DILUVIO = 2'd3
   } chuva_t;

   typedef enum logic {
      OCIOSO  = 1'b0,
      MEDINDO = 1'b1
   } estado_t;

   function automatic chuva_t classifica(input int n,
                                         input int lim_pouca,
                                         input int lim_muita,
                                         input int lim_diluvio);
      if (n < lim_pouca)        return NENHUMA;
      else if (n < lim_muita)   return POUCA;
      else if (n < lim_diluvio) return MUITA;
      else                      return DILUVIO;
   endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The edge flag rises three clocks after the input is first sampled high.
module sincroniza_borda (
   input  logic clk_2,
   input  logic reset,
   input  logic in,
   output logic borda
);

   logic sinc1_q, sinc2_q, ant_q, borda_q;

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         sinc1_q <= 1'b0;
         sinc2_q <= 1'b0;
         ant_q   <= 1'b0;
         borda_q <= 1'b0;
      end else begin
         sinc1_q <= in;
         sinc2_q <= sinc1_q;
         ant_q   <= sinc2_q;
         borda_q <= sinc2_q & ~ant_q;
      end
   end

   assign borda = borda_q;

endmodule

// File: rtl/sensor_chuva.sv
// Tipping-bucket rain gauge front end: counts gauge pulses over a window of
// JANELA clocks and publishes a 2-bit rain class with a 1-cycle valid strobe.
module sensor_chuva
   import pkg_irrigacao::*;
#(
   parameter int JANELA      = 16,
   parameter int CNT_BITS    = 5,
   parameter int LIM_POUCA   = 1,
   parameter int LIM_MUITA   = 3,
   parameter int LIM_DILUVIO = 6
) (
   input  logic                clk_2,
   input  logic                reset,
   input  logic                habilita,
   input  logic                pulso,
   output logic [1:0]          chuva,
   output logic                chuva_valida,
   output logic [CNT_BITS-1:0] pulsos_janela,
   output logic                saturado
);

   localparam int                 JW         = $clog2(JANELA);
   localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
   localparam logic [JW-1:0]      JANELA_FIM = JW'(JANELA - 1);

   estado_t             estado_q, estado_d;
   logic [JW-1:0]       janela_q, janela_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_final;
   chuva_t              chuva_q, chuva_d;
   logic                valida_q, valida_d;
   logic                saturado_q, saturado_d;
   logic                borda;

   sincroniza_borda u_sinc (
      .clk_2 (clk_2),
      .reset (reset),
      .in    (pulso),
      .borda (borda)
   );

   // An edge arriving in the closing cycle still belongs to the closing window.
   always_comb begin
      cnt_final = cnt_q;
      if (borda && (cnt_q != CNT_MAX))
         cnt_final = cnt_q + 1'b1;
   end

   always_comb begin
      estado_d   = estado_q;
      janela_d   = janela_q;
      cnt_d      = cnt_q;
      chuva_d    = chuva_q;
      valida_d   = 1'b0;
      saturado_d = saturado_q;
      case (estado_q)
         OCIOSO: begin
            janela_d = '0;
            cnt_d    = '0;
            if (habilita)
               estado_d = MEDINDO;
         end
         MEDINDO: begin
            if (!habilita) begin
               estado_d = OCIOSO;
               janela_d = '0;
               cnt_d    = '0;
            end else if (janela_q == JANELA_FIM) begin
               chuva_d    = classifica(32'(cnt_final), LIM_POUCA, LIM_MUITA, LIM_DILUVIO);
               valida_d   = 1'b1;
               saturado_d = (cnt_final == CNT_MAX);
               janela_d   = '0;
               cnt_d      = '0;
            end else begin
               janela_d = janela_q + 1'b1;
               cnt_d    = cnt_final;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         janela_q   <= '0;
         cnt_q      <= '0;
         chuva_q    <= NENHUMA;
         valida_q   <= 1'b0;
         saturado_q <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         janela_q   <= janela_d;
         cnt_q      <= cnt_d;
         chuva_q    <= chuva_d;
         valida_q   <= valida_d;
         saturado_q <= saturado_d;
      end
   end

   assign chuva         = chuva_q;
   assign chuva_valida  = valida_q;
   assign pulsos_janela = cnt_q;
   assign saturado      = saturado_q;

endmodule
